// File: rtl/traffic_pkg.sv
// Shared lamp codes, pedestrian phase encodings and default timer width,
// common to the traffic light controller and the pedestrian signal stage.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] WALK  = 2'b01;
    localparam logic [1:0] FLASH = 2'b10;

    localparam int PED_TW = 4;

    function automatic logic lamp_legal(input logic [2:0] code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

endpackage

// File: rtl/ped_phase_fsm.sv
// One crossing: request latch, green-rise detect, WALK/FLASH phase FSM and timer.
// Optional countdown output under PED_COUNTDOWN_EN.
module ped_phase_fsm
    import traffic_pkg::*;
#(
    parameter int WALK_CYC  = 3,
    parameter int FLASH_CYC = 2,
    parameter int TW        = PED_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    light_i,
    input  logic          btn_i,
    input  logic          fault_i,
    output logic          walk_o,
    output logic          flash_o,
`ifdef PED_COUNTDOWN_EN
    output logic [TW-1:0] count_o,
`endif
    output logic          pend_o
);

    localparam logic [TW-1:0] WALK_LAST  = TW'(WALK_CYC - 1);
    localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_CYC - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic          walk_q, walk_d, flash_q, flash_d, pend_q, pend_d, prev_g_q;
    logic          g, rise, serve;

    assign g         = (light_i == GREEN);
    assign rise      = g & ~prev_g_q;
    assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        walk_d  = walk_q;
        flash_d = flash_q;
        serve   = 1'b0;
        if (fault_i) begin
            state_d = IDLE;
            timer_d = '0;
            walk_d  = 1'b0;
            flash_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise && (pend_q || btn_i)) begin
                        serve   = 1'b1;
                        state_d = WALK;
                        timer_d = '0;
                        walk_d  = 1'b1;
                    end
                end
                WALK: begin
                    // Losing green mid-phase drops straight back to solid DON'T-WALK.
                    if (!g) begin
                        state_d = IDLE;
                        timer_d = '0;
                        walk_d  = 1'b0;
                        flash_d = 1'b0;
                    end else if (timer_q == WALK_LAST) begin
                        state_d = FLASH;
                        timer_d = '0;
                        walk_d  = 1'b0;
                        flash_d = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                FLASH: begin
                    if (!g || (timer_q == FLASH_LAST)) begin
                        state_d = IDLE;
                        timer_d = '0;
                        walk_d  = 1'b0;
                        flash_d = 1'b0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    walk_d  = 1'b0;
                    flash_d = 1'b0;
                end
            endcase
        end
        pend_d = serve ? 1'b0 : (pend_q | btn_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            walk_q   <= 1'b0;
            flash_q  <= 1'b0;
            pend_q   <= 1'b0;
            prev_g_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            walk_q   <= walk_d;
            flash_q  <= flash_d;
            pend_q   <= pend_d;
            prev_g_q <= g;
        end
    end

    assign walk_o  = walk_q;
    assign flash_o = flash_q;
    assign pend_o  = pend_q;

`ifdef PED_COUNTDOWN_EN
    assign count_o = (state_q == FLASH) ? (TW'(FLASH_CYC) - timer_q) : '0;
`endif

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal stage: two crossing FSMs plus a sticky lamp-conflict monitor.
// Define PED_COUNTDOWN_EN to add the ns_count/ew_count flash countdown outputs.
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int WALK_CYC  = 3,
    parameter int FLASH_CYC = 2,
    parameter int TW        = PED_TW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    nslight,
    input  logic [2:0]    ewlight,
    input  logic          ns_btn,
    input  logic          ew_btn,
    output logic          ns_walk,
    output logic          ns_flash,
    output logic          ew_walk,
    output logic          ew_flash,
    output logic          ns_pend,
    output logic          ew_pend,
`ifdef PED_COUNTDOWN_EN
    output logic [TW-1:0] ns_count,
    output logic [TW-1:0] ew_count,
`endif
    output logic          fault
);

    logic fault_q, conflict;
    logic ns_walk_raw, ns_flash_raw, ew_walk_raw, ew_flash_raw;

    assign conflict = !lamp_legal(nslight) || !lamp_legal(ewlight)
                    || ((nslight != RED) && (ewlight != RED));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_q | conflict;
        end
    end

`ifdef PED_COUNTDOWN_EN
    logic [TW-1:0] ns_count_raw, ew_count_raw;
`endif

    ped_phase_fsm #(.WALK_CYC(WALK_CYC), .FLASH_CYC(FLASH_CYC), .TW(TW)) u_ns (
        .clk     (clk),
        .reset   (reset),
        .light_i (nslight),
        .btn_i   (ns_btn),
        .fault_i (fault_q),
        .walk_o  (ns_walk_raw),
        .flash_o (ns_flash_raw),
`ifdef PED_COUNTDOWN_EN
        .count_o (ns_count_raw),
`endif
        .pend_o  (ns_pend)
    );

    ped_phase_fsm #(.WALK_CYC(WALK_CYC), .FLASH_CYC(FLASH_CYC), .TW(TW)) u_ew (
        .clk     (clk),
        .reset   (reset),
        .light_i (ewlight),
        .btn_i   (ew_btn),
        .fault_i (fault_q),
        .walk_o  (ew_walk_raw),
        .flash_o (ew_flash_raw),
`ifdef PED_COUNTDOWN_EN
        .count_o (ew_count_raw),
`endif
        .pend_o  (ew_pend)
    );

    // The FSMs only reach IDLE one edge after fault rises, so mask here too.
    assign ns_walk  = ns_walk_raw & ~fault_q;
    assign ew_walk  = ew_walk_raw & ~fault_q;
    assign ns_flash = ns_flash_raw | fault_q;
    assign ew_flash = ew_flash_raw | fault_q;
    assign fault    = fault_q;

`ifdef PED_COUNTDOWN_EN
    assign ns_count = fault_q ? '0 : ns_count_raw;
    assign ew_count = fault_q ? '0 : ew_count_raw;
`endif

endmodule
